// File: rtl/add_seq_ctrl.sv
// Two-requester round-robin adder front end. One shared 4-bit ripple-carry
// slice processes the operands one nibble per cycle, LSB nibble first.
module add_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_nxt_s;
  logic [W-1:0]    a_r, b_r;
  logic            carry_r;
  logic [CW-1:0]   cnt_r;
  logic            last_r;
  logic            grant_vld_s, grant_id_s, accept_s;
  logic [CW+1:0]   idx_s;
  logic [4:0]      slice_s;

  function automatic logic [4:0] ripple_add4(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin);
    logic [3:0] s;
    logic       c;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ~last_r;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // rst_n gating keeps both readies low for the whole reset pulse.
  assign accept_s   = rst_n && (state_r == IDLE) && grant_vld_s;
  assign req0_ready = accept_s && !grant_id_s;
  assign req1_ready = accept_s && grant_id_s;

  assign idx_s   = {cnt_r, 2'b00};
  assign slice_s = ripple_add4(a_r[idx_s +: 4], b_r[idx_s +: 4], carry_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = ADD;
        else          state_nxt_s = IDLE;
      end
      ADD: begin
        if (cnt_r == LAST_CNT) state_nxt_s = DONE;
        else                   state_nxt_s = ADD;
      end
      DONE: begin
        if (rsp_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, nibble-serial accumulation and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      carry_r   <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      last_r    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= {W{1'b0}};
      rsp_cout  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= grant_id_s ? req1_a : req0_a;
            b_r     <= grant_id_s ? req1_b : req0_b;
            carry_r <= grant_id_s ? req1_cin : req0_cin;
            cnt_r   <= {CW{1'b0}};
            rsp_id  <= grant_id_s;
            last_r  <= grant_id_s;
          end
        end
        ADD: begin
          rsp_sum[idx_s +: 4] <= slice_s[3:0];
          carry_r             <= slice_s[4];
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= {CW{1'b0}};
            rsp_cout  <= slice_s[4];
            rsp_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model (grant rule, due time, A+B+cin).
module tb_add_seq_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level model state.
  int           cyc = 0;
  int           due = 0;
  bit           busy = 1'b0;
  int           last_g = 1;
  logic [W-1:0] exp_sum;
  logic         exp_cout, exp_id;
  bit           acc0, acc1, hs;
  logic         hs_id, hs_cout;
  logic [W-1:0] hs_sum;
  int           mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_req(input int i);
    if (i == 0) begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    end else begin
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
    end
  endtask

  // One clock cycle: check at negedge+1, advance the model at posedge, update drivers.
  task automatic step();
    int           g;
    logic         exp_rv;
    logic [W:0]   tot;
    acc0 = 1'b0; acc1 = 1'b0; hs = 1'b0;
    #1;
    if (!rst_n) begin
      busy = 1'b0;
      last_g = 1;
    end
    g = -1;
    if (rst_n && !busy) begin
      if (req0_valid && req1_valid) g = (last_g == 0) ? 1 : 0;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    exp_rv = rst_n && busy && (cyc >= due);
    check("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
    if (!rst_n) begin
      check("reset_sum", {16'd0, rsp_sum}, 32'd0);
      check("reset_cout", {31'd0, rsp_cout}, 32'd0);
      check("reset_id", {31'd0, rsp_id}, 32'd0);
    end else if (exp_rv) begin
      check("rsp_sum", {16'd0, rsp_sum}, {16'd0, exp_sum});
      check("rsp_cout", {31'd0, rsp_cout}, {31'd0, exp_cout});
      check("rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
      if (rsp_ready) begin
        hs = 1'b1; hs_id = rsp_id; hs_sum = rsp_sum; hs_cout = rsp_cout;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (hs) begin
        busy = 1'b0;
      end else if (g >= 0) begin
        busy = 1'b1;
        due = cyc + NIBBLES;
        last_g = g;
        if (g == 0) tot = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
        else        tot = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
        exp_sum = tot[W-1:0];
        exp_cout = tot[W];
        exp_id = (g == 1);
        if (g == 0) acc0 = 1'b1; else acc1 = 1'b1;
      end
    end
    @(negedge clk);
    case (mode)
      0: begin
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
      end
      1: begin
        if (acc0) rand_req(0);
        if (acc1) rand_req(1);
      end
      default: begin
        if (acc0 || !req0_valid) begin req0_valid = ($urandom_range(0, 2) != 0); rand_req(0); end
        if (acc1 || !req1_valid) begin req1_valid = ($urandom_range(0, 2) != 0); rand_req(1); end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic run_until_hs(input int max_cycles);
    int n;
    n = 0;
    step();
    while (!hs && n < max_cycles) begin
      step();
      n++;
    end
    check("hs_timeout", {31'd0, hs}, 32'd1);
  endtask

  initial begin
    int   ids[4];
    int   nh, n;
    logic prev_id;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // 0x00FF + 0x0001 from requester 0
    mode = 0;
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
    run_until_hs(20);
    check("d1_sum", {16'd0, hs_sum}, 32'h0000_0100);
    check("d1_cout", {31'd0, hs_cout}, 32'd0);
    check("d1_id", {31'd0, hs_id}, 32'd0);

    // 0xFFFF + 0x0000 + 1 from requester 1
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1;
    run_until_hs(20);
    check("d2_sum", {16'd0, hs_sum}, 32'h0000_0000);
    check("d2_cout", {31'd0, hs_cout}, 32'd1);
    check("d2_id", {31'd0, hs_id}, 32'd1);

    // Both requesters valid from reset release: ids must alternate 0,1,0,1
    rst_n = 1'b0;
    step();
    mode = 1;
    req0_valid = 1'b1; rand_req(0);
    req1_valid = 1'b1; rand_req(1);
    rst_n = 1'b1;
    nh = 0; n = 0;
    while (nh < 4 && n < 60) begin
      step();
      if (hs) begin ids[nh] = int'(hs_id); nh++; end
      n++;
    end
    check("rr_count", nh, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_id%0d", i), ids[i], i % 2);

    // Back-pressure in DONE with both requesters still valid
    rsp_ready = 1'b0;
    n = 0;
    while (!(busy && cyc >= due) && n < 12) begin step(); n++; end
    check("bp_reach_done", {31'd0, busy && cyc >= due}, 32'd1);
    prev_id = exp_id;
    for (int i = 0; i < 3; i++) step();
    rsp_ready = 1'b1;
    step();
    check("bp_hs", {31'd0, hs}, 32'd1);
    #1;
    check("bp_other_ready", {31'd0, (prev_id == 1'b0) ? req1_ready : req0_ready}, 32'd1);
    check("bp_same_ready", {31'd0, (prev_id == 1'b0) ? req0_ready : req1_ready}, 32'd0);
    step();

    // Drain, then abort an add with reset two cycles into ADD
    mode = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_until_hs(20);
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0;
    step();
    check("abort_accept", {31'd0, acc0}, 32'd1);
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0;
    run_until_hs(20);
    check("d4_sum", {16'd0, hs_sum}, 32'h0000_2345);
    check("d4_cout", {31'd0, hs_cout}, 32'd0);
    check("d4_id", {31'd0, hs_id}, 32'd0);

    // Random traffic with random back-pressure
    mode = 2;
    for (int i = 0; i < 400; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
